hash_lane_buffer: RTL
=====================

# hash_lane_buffer

Parametrised, single-clock, multi-lane result buffer that sits between the key-hash engine and the hash-table lookup stage. It replaces separately instantiated per-hash FIFOs with one lock-step store: every accepted write captures all lanes of one key's hash set, and every accepted read releases them together. Full and empty are therefore exact and shared by all lanes. The block adds almost-full back-pressure, an occupancy count, sticky overflow/underflow error flags and a selectable first-word-fall-through read mode.

## Interface
Parameters:
- LANES, 3, number of hash lanes (1..8)
- LANE_WIDTH, 28, bits per lane; narrower hashes are zero-extended in their lane
- DEPTH, 16, entries; power of two, 4..1024
- AFULL_THRESH, 12, oWrHashAlmostFull asserts when count >= this value (1..DEPTH)
- FWFT, 1, 1 = first-word-fall-through; 0 = standard read with 1-cycle latency

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-low
- iWrHashFifo_en  in  1  write request
- iKeyHash  in  LANES*LANE_WIDTH  write data; lane k occupies bits [k*LANE_WIDTH +: LANE_WIDTH]
- oWrHashFull  out  1  count == DEPTH
- oWrHashAlmostFull  out  1  count >= AFULL_THRESH
- iRdHashFifo_en  in  1  read request
- oRdHashEmpty  out  1  count == 0
- oKeyHash  out  LANES*LANE_WIDTH  read data, same lane packing as iKeyHash
- oCount  out  $clog2(DEPTH)+1  occupancy
- iClrErr  in  1  clears the sticky error flags
- oOverflow  out  1  sticky; set on a write request while full
- oUnderflow  out  1  sticky; set on a read request while empty

## Operation
- Storage: DEPTH x (LANES*LANE_WIDTH) memory, plus a write pointer and a read pointer, each $clog2(DEPTH) bits. Pointers wrap naturally from DEPTH-1 to 0.
- Write acceptance: wr_ok = iWrHashFifo_en & !oWrHashFull. A read in the same cycle does not free space; a write while full is dropped and sets oOverflow.
- Read acceptance: rd_ok = iRdHashFifo_en & !oRdHashEmpty. A write in the same cycle does not make data readable; a read while empty is ignored and sets oUnderflow.
- Count update:
  - +1 on wr_ok only
  - −1 on rd_ok only
  - unchanged when both or neither occur
- Flags: oWrHashFull, oRdHashEmpty and oWrHashAlmostFull are decoded from the registered count, with no extra cycle of delay.
- Error flags:
  - iClrErr clears both flags.
  - If a new error occurs in the same cycle as iClrErr, the set wins.
- Read data, FWFT=1: oKeyHash always shows mem[rd_ptr] and is valid whenever oRdHashEmpty=0. After rd_ok it shows the next entry in the following cycle.
- Read data, FWFT=0: oKeyHash is a register loaded with mem[rd_ptr] on rd_ok. It is valid the cycle after rd_ok and holds its value otherwise.
- Lanes are never independently enabled; one write = one entry across all lanes.
- Reset (rst=0 at a clock edge):
  - pointers, count, oOverflow, oUnderflow -> 0
  - oRdHashEmpty=1, oWrHashFull=0, oWrHashAlmostFull=0
  - oKeyHash register (FWFT=0) -> 0
  - Memory contents are not cleared.
  - Reset in mid-stream discards all entries. Requests in the reset cycle are ignored and set no flags.

## Timing
- Write-to-read visibility: data written at edge N gives oRdHashEmpty=0 after edge N. With FWFT=1, oKeyHash is valid in that same cycle (1-cycle latency).
- FWFT=0: rd_ok at edge M presents data after edge M.
- Full asserts after the edge that accepts write number DEPTH. It deasserts after the first edge with rd_ok and no wr_ok.
- Sustained simultaneous read+write at 0 < count < DEPTH gives one entry per cycle with count constant.
- At count=0, simultaneous read and write: the write is accepted, count becomes 1, and oUnderflow is set.
- At count=DEPTH, simultaneous read and write: the read is accepted, count becomes DEPTH−1, and oOverflow is set.

## Test plan
- Reset/fill/drain, defaults, FWFT=1:
  - After reset: oRdHashEmpty=1, oCount=0.
  - Write 16 entries with lane values {k, 0x100+k, 0x200+k}, k=0..15: oWrHashAlmostFull rises after the 12th write, oWrHashFull after the 16th.
  - Read 16: data returns in order, exact per lane; oRdHashEmpty=1 after the last read.
- Overflow/underflow:
  - A 17th write while full: data unchanged, oOverflow=1.
  - Reading an empty buffer: oUnderflow=1.
  - iClrErr: both flags 0 next cycle.
- Simultaneous access:
  - At count=5, 20 cycles of read+write: oCount stays 5, FIFO order preserved.
  - At count=0, read+write: count becomes 1, oUnderflow=1.
  - At count=16, read+write: count becomes 15, oOverflow=1.
- Wrap-around: 100 random-gap writes/reads at DEPTH=4 against a reference model; zero mismatches, pointers wrap cleanly.
- FWFT=0, LANES=2, LANE_WIDTH=24:
  - Write 0xABCDEF/0x123456, then read: oKeyHash equals the entry one cycle after rd_ok and holds while idle.
- Reset mid-stream:
  - At count=7, assert rst for one cycle with both requests high: oCount=0, oRdHashEmpty=1, no error flags.
  - A subsequent write/read round-trips correctly.

Source files
------------

// File: rtl/hash_lane_buffer.sv
// Lock-step multi-lane hash result buffer: one entry holds every lane of a key's hash set.
// Shared exact full/empty, almost-full back-pressure, sticky error flags, optional FWFT read.
module hash_lane_buffer #(
    parameter int LANES        = 3,
    parameter int LANE_WIDTH   = 28,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 12,
    parameter int FWFT         = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          iWrHashFifo_en,
    input  logic [LANES*LANE_WIDTH-1:0]   iKeyHash,
    output logic                          oWrHashFull,
    output logic                          oWrHashAlmostFull,
    input  logic                          iRdHashFifo_en,
    output logic                          oRdHashEmpty,
    output logic [LANES*LANE_WIDTH-1:0]   oKeyHash,
    output logic [$clog2(DEPTH):0]        oCount,
    input  logic                          iClrErr,
    output logic                          oOverflow,
    output logic                          oUnderflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = LANES * LANE_WIDTH;
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic          wrOk;
    logic          rdOk;

    assign oWrHashFull       = (count == CW'(DEPTH));
    assign oRdHashEmpty      = (count == '0);
    assign oWrHashAlmostFull = (count >= CW'(AFULL_THRESH));
    assign oCount            = count;

    // Acceptance looks only at the registered count, so a same-cycle read never frees space
    // for a write and a same-cycle write never makes data readable.
    assign wrOk = iWrHashFifo_en & ~oWrHashFull;
    assign rdOk = iRdHashFifo_en & ~oRdHashEmpty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            oOverflow  <= 1'b0;
            oUnderflow <= 1'b0;
        end else begin
            if (wrOk) wrPtr <= wrPtr + AW'(1);
            if (rdOk) rdPtr <= rdPtr + AW'(1);
            case ({wrOk, rdOk})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            oOverflow  <= (oOverflow  & ~iClrErr) | (iWrHashFifo_en & oWrHashFull);
            oUnderflow <= (oUnderflow & ~iClrErr) | (iRdHashFifo_en & oRdHashEmpty);
        end
    end

    // Storage is deliberately not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (rst && wrOk) mem[wrPtr] <= iKeyHash;
    end

    generate
        if (FWFT != 0) begin : gFwft
            assign oKeyHash = mem[rdPtr];
        end else begin : gStd
            logic [DW-1:0] keyReg;
            always_ff @(posedge clk) begin
                if (!rst)      keyReg <= '0;
                else if (rdOk) keyReg <= mem[rdPtr];
            end
            assign oKeyHash = keyReg;
        end
    endgenerate
endmodule
